regfile_mp: RTL and testbench

//  Parametrised multi-read-port register file with write-to-read bypass, optional

---
 rtl/regfile_mp_if.sv | 29 ++
 rtl/regfile_mp.sv | 73 +++++++
 tb/tb_regfile_mp.sv | 130 +++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Register-file port bundle: writeback, multi-port read, and scoreboard alloc/busy.
// Decode/writeback side drives through master; the register file uses slave.
interface regfile_mp_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
);
  localparam int AW = $clog2(NREGS);

  logic                we;
  logic [AW-1:0]       write_addr;
  logic [XLEN-1:0]     result;
  logic [NRD-1:0]      re;
  logic [NRD*AW-1:0]   source;
  logic [NRD*XLEN-1:0] op;
  logic                alloc;
  logic [AW-1:0]       alloc_addr;
  logic [NRD-1:0]      busy;

  modport master (
    output we, write_addr, result, re, source, alloc, alloc_addr,
    input  op, busy
  );

  modport slave (
    input  we, write_addr, result, re, source, alloc, alloc_addr,
    output op, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with writeback bypass and per-register busy scoreboard.
// Read latency 0 (REG_READ=0) or 1 (REG_READ=1); no backpressure, busy is advisory to decode.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int ZERO_R0  = 1,
  parameter int REG_READ = 0
) (
  input logic         clk,
  input logic         clrn,
  regfile_mp_if.slave rf
);
  localparam int AW = $clog2(NREGS);
  localparam bit Z0 = (ZERO_R0 != 0);

  logic [XLEN-1:0]     regs [NREGS];
  logic [NREGS-1:0]    sb;
  logic [AW-1:0]       src  [NRD];
  logic [NRD*XLEN-1:0] vals;
  logic                wr_ok;
  logic                alloc_ok;

  assign wr_ok    = rf.we    && !(Z0 && rf.write_addr == '0);
  assign alloc_ok = rf.alloc && !(Z0 && rf.alloc_addr == '0);

  for (genvar g = 0; g < NRD; g++) begin : g_src
    assign src[g] = rf.source[g*AW +: AW];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      sb <= '0;
    end else begin
      if (wr_ok) regs[rf.write_addr] <= rf.result;
      if (rf.we) sb[rf.write_addr] <= 1'b0;
      // Alloc applied after the clear so a new producer wins over a retiring one.
      if (alloc_ok) sb[rf.alloc_addr] <= 1'b1;
    end
  end

  always_comb begin
    vals    = '0;
    rf.busy = '0;
    for (int i = 0; i < NRD; i++) begin
      if (Z0 && src[i] == '0)
        vals[i*XLEN +: XLEN] = '0;
      else if (wr_ok && rf.write_addr == src[i])
        vals[i*XLEN +: XLEN] = rf.result;
      else
        vals[i*XLEN +: XLEN] = regs[src[i]];
      rf.busy[i] = sb[src[i]] && !(rf.we && rf.write_addr == src[i]);
    end
  end

  if (REG_READ != 0) begin : g_reg_read
    logic [NRD*XLEN-1:0] op_q;
    always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
        op_q <= '0;
      end else begin
        for (int i = 0; i < NRD; i++)
          if (rf.re[i]) op_q[i*XLEN +: XLEN] <= vals[i*XLEN +: XLEN];
      end
    end
    assign rf.op = op_q;
  end else begin : g_comb_read
    logic unused_re;
    assign unused_re = ^rf.re;
    assign rf.op = vals;
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench driving a combinational-read and a registered-read instance in lockstep.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        clrn;
  logic        we, alloc;
  logic [4:0]  wa, aa, src0, src1;
  logic [31:0] res;
  logic [1:0]  re;
  int          total = 0;
  int          passed = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) rc ();
  regfile_mp_if #(.XLEN(32), .NREGS(32), .NRD(2)) rr ();

  assign rc.we = we;  assign rc.write_addr = wa; assign rc.result = res;
  assign rc.re = re;  assign rc.source = {src1, src0};
  assign rc.alloc = alloc; assign rc.alloc_addr = aa;
  assign rr.we = we;  assign rr.write_addr = wa; assign rr.result = res;
  assign rr.re = re;  assign rr.source = {src1, src0};
  assign rr.alloc = alloc; assign rr.alloc_addr = aa;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_R0(1), .REG_READ(0)) u_comb (
    .clk(clk), .clrn(clrn), .rf(rc.slave));
  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_R0(1), .REG_READ(1)) u_reg (
    .clk(clk), .clrn(clrn), .rf(rr.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clrn = 1'b0; we = 0; alloc = 0; wa = 0; aa = 0; res = 0; re = 0; src0 = 0; src1 = 0;
    #3;
    total++; if (rc.op !== 64'h0) $display("FAIL reset_comb_op got=%h exp=0", rc.op); else passed++;
    total++; if (rr.op !== 64'h0) $display("FAIL reset_reg_op got=%h exp=0", rr.op); else passed++;
    total++; if (rc.busy !== 2'b00) $display("FAIL reset_busy got=%b exp=00", rc.busy); else passed++;
    tick(); clrn = 1'b1; tick();
    we = 1; wa = 5; res = 32'hDEADBEEF; alloc = 1; aa = 6; re = 2'b11; src0 = 5; src1 = 6;
    #1;
    total++; if (rc.op[31:0] !== 32'hDEADBEEF) $display("FAIL r5_bypass got=%h exp=deadbeef", rc.op[31:0]); else passed++;
    total++; if (rc.busy !== 2'b00) $display("FAIL alloc_same_cycle got=%b exp=00", rc.busy); else passed++;
    tick(); we = 0; alloc = 0; #1;
    total++; if (rc.busy !== 2'b10) $display("FAIL r6_busy got=%b exp=10", rc.busy); else passed++;
    total++; if (rr.op[31:0] !== 32'hDEADBEEF) $display("FAIL r5_reg got=%h exp=deadbeef", rr.op[31:0]); else passed++;
    #2 clrn = 1'b0; #1;
    total++; if (rc.op[31:0] !== 32'h0) $display("FAIL midreset_op got=%h exp=0", rc.op[31:0]); else passed++;
    total++; if (rc.busy !== 2'b00) $display("FAIL midreset_busy got=%b exp=00", rc.busy); else passed++;
    total++; if (rr.op !== 64'h0) $display("FAIL midreset_reg_op got=%h exp=0", rr.op); else passed++;
    tick(); clrn = 1'b1; re = 0;
  endtask

  task automatic test_bypass();
    we = 1; wa = 7; res = 32'h1234; src0 = 7; re = 2'b01; #1;
    total++; if (rc.op[31:0] !== 32'h1234) $display("FAIL bypass_comb got=%h exp=1234", rc.op[31:0]); else passed++;
    tick(); we = 0; #1;
    total++; if (rr.op[31:0] !== 32'h1234) $display("FAIL bypass_reg got=%h exp=1234", rr.op[31:0]); else passed++;
    total++; if (rc.op[31:0] !== 32'h1234) $display("FAIL r7_after got=%h exp=1234", rc.op[31:0]); else passed++;
    re = 0;
  endtask

  task automatic test_r0();
    we = 1; wa = 0; res = 32'hFFFFFFFF; alloc = 1; aa = 0; src0 = 0; src1 = 0; re = 2'b11; #1;
    total++; if (rc.op[31:0] !== 32'h0) $display("FAIL r0_bypass got=%h exp=0", rc.op[31:0]); else passed++;
    total++; if (rc.busy !== 2'b00) $display("FAIL r0_busy_same got=%b exp=00", rc.busy); else passed++;
    tick(); we = 0; alloc = 0; #1;
    total++; if (rc.op[63:32] !== 32'h0) $display("FAIL r0_read got=%h exp=0", rc.op[63:32]); else passed++;
    total++; if (rc.busy !== 2'b00) $display("FAIL r0_busy_after got=%b exp=00", rc.busy); else passed++;
    total++; if (rr.op !== 64'h0) $display("FAIL r0_reg got=%h exp=0", rr.op); else passed++;
  endtask

  task automatic test_scoreboard();
    alloc = 1; aa = 3; src0 = 3; src1 = 3; re = 2'b11; #1;
    total++; if (rc.busy !== 2'b00) $display("FAIL sb_same_cycle got=%b exp=00", rc.busy); else passed++;
    tick(); alloc = 0; #1;
    total++; if (rc.busy !== 2'b11) $display("FAIL sb_busy got=%b exp=11", rc.busy); else passed++;
    total++; if (rr.busy !== 2'b11) $display("FAIL sb_busy_reg got=%b exp=11", rr.busy); else passed++;
    tick();
    total++; if (rc.busy[1] !== 1'b1) $display("FAIL sb_hold got=%b exp=1", rc.busy[1]); else passed++;
    we = 1; wa = 3; res = 32'hCAFE0003; #1;
    total++; if (rc.busy !== 2'b00) $display("FAIL sb_wb_inflight got=%b exp=00", rc.busy); else passed++;
    total++; if (rc.op[63:32] !== 32'hCAFE0003) $display("FAIL sb_wb_op got=%h exp=cafe0003", rc.op[63:32]); else passed++;
    tick(); we = 0; #1;
    total++; if (rc.busy !== 2'b00) $display("FAIL sb_cleared got=%b exp=00", rc.busy); else passed++;
    total++; if (rr.op[63:32] !== 32'hCAFE0003) $display("FAIL sb_reg_op got=%h exp=cafe0003", rr.op[63:32]); else passed++;
    re = 0;
  endtask

  task automatic test_simul_alloc_we();
    we = 1; wa = 9; res = 32'h99; alloc = 1; aa = 9; src0 = 9; #1;
    total++; if (rc.busy[0] !== 1'b0) $display("FAIL simul_inflight got=%b exp=0", rc.busy[0]); else passed++;
    tick(); we = 0; alloc = 0; #1;
    total++; if (rc.busy[0] !== 1'b1) $display("FAIL simul_busy got=%b exp=1", rc.busy[0]); else passed++;
    total++; if (rc.op[31:0] !== 32'h99) $display("FAIL simul_val got=%h exp=99", rc.op[31:0]); else passed++;
  endtask

  task automatic test_hold();
    we = 1; wa = 4; res = 32'h1; src0 = 4; re = 2'b01;
    tick(); we = 0; re = 0; #1;
    total++; if (rr.op[31:0] !== 32'h1) $display("FAIL hold_first got=%h exp=1", rr.op[31:0]); else passed++;
    we = 1; res = 32'h2;
    tick(); we = 0; #1;
    total++; if (rr.op[31:0] !== 32'h1) $display("FAIL hold_kept got=%h exp=1", rr.op[31:0]); else passed++;
    total++; if (rc.op[31:0] !== 32'h2) $display("FAIL hold_comb got=%h exp=2", rc.op[31:0]); else passed++;
    re = 2'b01;
    tick(); re = 0; #1;
    total++; if (rr.op[31:0] !== 32'h2) $display("FAIL hold_release got=%h exp=2", rr.op[31:0]); else passed++;
  endtask

  task automatic test_same_addr_ports();
    src0 = 7; src1 = 7; re = 2'b11;
    tick(); re = 0; #1;
    total++; if (rc.op !== {32'h1234, 32'h1234}) $display("FAIL same_addr_comb got=%h exp=12341234 pair", rc.op); else passed++;
    total++; if (rr.op !== {32'h1234, 32'h1234}) $display("FAIL same_addr_reg got=%h exp=12341234 pair", rr.op); else passed++;
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_r0();
    test_scoreboard();
    test_simul_alloc_we();
    test_hold();
    test_same_addr_ports();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
